// File: rtl/serial_lane_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_lane_arbiter
// Description : Round-robin sharing of one serial-to-parallel deserializer
//               among N_SRC serial lanes, with word tagging and stall abort.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_lane_arbiter #(
  parameter int N_SRC       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WORDS = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_req,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0]         src_bit,
  output logic [N_SRC-1:0]         src_grant,
  output logic [N_SRC-1:0]         src_done,
  output logic [N_SRC-1:0]         src_err,
  output logic                     s2p_valid,
  output logic                     s2p_data,
  output logic                     s2p_clr,
  input  logic                     s2p_ready,
  input  logic [DATA_WIDTH-1:0]    s2p_word,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(N_SRC)-1:0] out_src,
  output logic                     out_last
);

  localparam int c_SW = $clog2(N_SRC);
  localparam int c_BW = $clog2(DATA_WIDTH + 1);
  localparam int c_WW = $clog2(BURST_WORDS + 1);
  localparam int c_IW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_SW-1:0] c_LAST_SRC  = c_SW'(N_SRC - 1);
  localparam logic [c_SW:0]   c_NSRC_EXT  = (c_SW + 1)'(N_SRC);
  localparam logic [c_BW-1:0] c_WORD_BITS = c_BW'(DATA_WIDTH);
  localparam logic [c_WW-1:0] c_BURST     = c_WW'(BURST_WORDS);
  localparam logic [c_IW-1:0] c_TIMEOUT   = c_IW'(TIMEOUT_CYC);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_XFER    = 3'd1;
  localparam logic [2:0] c_WAIT    = 3'd2;
  localparam logic [2:0] c_RELEASE = 3'd3;
  localparam logic [2:0] c_ABORT   = 3'd4;

  logic [2:0]            r_state;
  logic [c_SW-1:0]       r_rr_ptr;
  logic [c_SW-1:0]       r_gid;
  logic [N_SRC-1:0]      r_grant;
  logic [c_BW-1:0]       r_bit_cnt;
  logic [c_WW-1:0]       r_word_cnt;
  logic [c_IW-1:0]       r_idle_cnt;
  logic [N_SRC-1:0]      r_done;
  logic [N_SRC-1:0]      r_err;
  logic                  r_s2p_valid;
  logic                  r_s2p_data;
  logic                  r_s2p_clr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [c_SW-1:0]       r_out_src;
  logic                  r_out_last;

  logic                  w_pick_found;
  logic [c_SW-1:0]       w_pick;
  logic [c_SW:0]         w_idx;
  logic [N_SRC-1:0]      w_pick_oh;
  logic                  w_bit;
  logic [c_SW-1:0]       w_gid_next;
  logic [c_BW-1:0]       w_bit_cnt_inc;
  logic [c_WW-1:0]       w_word_cnt_inc;
  logic [c_IW-1:0]       w_idle_cnt_inc;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_idx        = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (c_SW + 1)'(i);
      if (w_idx >= c_NSRC_EXT) w_idx = w_idx - c_NSRC_EXT;
      if (!w_pick_found && src_req[w_idx[c_SW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick       = w_idx[c_SW-1:0];
      end
    end
  end

  assign w_pick_oh      = N_SRC'(1) << w_pick;
  assign w_bit          = (r_state == c_XFER) & src_valid[r_gid] & r_grant[r_gid];
  assign w_gid_next     = (r_gid == c_LAST_SRC) ? '0 : r_gid + 1'b1;
  assign w_bit_cnt_inc  = r_bit_cnt + 1'b1;
  assign w_word_cnt_inc = r_word_cnt + 1'b1;
  assign w_idle_cnt_inc = r_idle_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_grant     <= '0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_s2p_valid <= 1'b0;
      r_s2p_data  <= 1'b0;
      r_s2p_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_done      <= '0;
      r_err       <= '0;
      r_s2p_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_s2p_valid <= w_bit;
      r_s2p_data  <= w_bit & src_bit[r_gid];
      case (r_state)
        c_IDLE: begin
          if (w_pick_found) begin
            r_gid      <= w_pick;
            r_grant    <= w_pick_oh;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= c_XFER;
          end
        end
        c_XFER: begin
          if (w_bit) begin
            r_idle_cnt <= '0;
            r_bit_cnt  <= w_bit_cnt_inc;
            if (w_bit_cnt_inc == c_WORD_BITS) r_state <= c_WAIT;
          end else if (r_idle_cnt == c_TIMEOUT) begin
            r_s2p_clr <= 1'b1;
            r_err     <= r_grant;
            r_state   <= c_ABORT;
          end else begin
            r_idle_cnt <= w_idle_cnt_inc;
          end
        end
        c_WAIT: begin
          // A completed word takes priority over a coincident timeout.
          if (s2p_ready) begin
            r_out_valid <= 1'b1;
            r_out_data  <= s2p_word;
            r_out_src   <= r_gid;
            r_word_cnt  <= w_word_cnt_inc;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            if ((w_word_cnt_inc == c_BURST) || !src_req[r_gid]) begin
              r_out_last <= 1'b1;
              r_done     <= r_grant;
              r_state    <= c_RELEASE;
            end else begin
              r_state <= c_XFER;
            end
          end else if (r_idle_cnt == c_TIMEOUT) begin
            r_s2p_clr <= 1'b1;
            r_err     <= r_grant;
            r_state   <= c_ABORT;
          end else begin
            r_idle_cnt <= w_idle_cnt_inc;
          end
        end
        c_RELEASE, c_ABORT: begin
          r_grant  <= '0;
          r_rr_ptr <= w_gid_next;
          r_state  <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign src_grant = r_grant;
  assign src_done  = r_done;
  assign src_err   = r_err;
  assign s2p_valid = r_s2p_valid;
  assign s2p_data  = r_s2p_data;
  assign s2p_clr   = r_s2p_clr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_serial_lane_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_lane_arbiter
// Description : Scoreboard bench for serial_lane_arbiter with a behavioural
//               deserializer and per-lane serial bit feeders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_lane_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_req, src_valid, src_bit;
  logic [N-1:0]  src_grant, src_done, src_err;
  logic          s2p_valid, s2p_data, s2p_clr, s2p_ready;
  logic [DW-1:0] s2p_word;
  logic          out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;

  serial_lane_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .BURST_WORDS(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_valid(src_valid), .src_bit(src_bit),
    .src_grant(src_grant), .src_done(src_done), .src_err(src_err),
    .s2p_valid(s2p_valid), .s2p_data(s2p_data), .s2p_clr(s2p_clr),
    .s2p_ready(s2p_ready), .s2p_word(s2p_word),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] src; logic [7:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic lane_bits [N][256];
  int   lane_wr [N];
  int   lane_rd [N];
  int   lane_cnt[N];
  bit   lane_hold[N];
  bit   req_en[N];
  bit   noise = 1'b0;

  logic          force_ready = 1'b0;
  logic [DW-1:0] force_word  = '0;

  logic [63:0] glog, dlog, elog;
  int gcnt, dcnt, ecnt, sv_cnt, ov_cnt, clr_cnt, err_cyc;
  int cyc = 0;
  int grant_cyc[N];
  logic [N-1:0] prev_grant = '0;

  // Behavioural deserializer: MSB-first shift, word strobe one cycle after the last bit.
  logic [DW-1:0] ds_sh    = '0;
  logic [DW-1:0] ds_word  = '0;
  logic [3:0]    ds_cnt   = '0;
  logic          ds_ready = 1'b0;
  always @(posedge clk) begin
    ds_ready <= 1'b0;
    if (rst || s2p_clr) begin
      ds_cnt <= '0;
    end else if (s2p_valid) begin
      ds_sh <= {ds_sh[DW-2:0], s2p_data};
      if (ds_cnt == 4'd7) begin
        ds_ready <= 1'b1;
        ds_word  <= {ds_sh[DW-2:0], s2p_data};
        ds_cnt   <= '0;
      end else begin
        ds_cnt <= ds_cnt + 4'd1;
      end
    end
  end
  assign s2p_ready = ds_ready | force_ready;
  assign s2p_word  = force_ready ? force_word : ds_word;

  // Lane feeders: one word per grant slot, then hold until that word is returned.
  initial begin
    src_req = '0; src_valid = '0; src_bit = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (!src_grant[k]) lane_hold[k] = 1'b0;
        if (out_valid && !out_last && (int'(out_src) == k)) lane_hold[k] = 1'b0;
        if (src_err[k]) begin lane_cnt[k] = 0; lane_hold[k] = 1'b0; end
        src_valid[k] = 1'b0;
        src_bit[k]   = 1'b0;
        if (src_grant[k] && !lane_hold[k] && (lane_rd[k] < lane_wr[k])) begin
          src_valid[k] = 1'b1;
          src_bit[k]   = lane_bits[k][lane_rd[k]];
          lane_rd[k]++;
          lane_cnt[k]++;
          if (lane_cnt[k] == DW) begin lane_cnt[k] = 0; lane_hold[k] = 1'b1; end
        end else if (!src_grant[k] && noise) begin
          src_valid[k] = 1'b1;
          src_bit[k]   = 1'($urandom_range(0, 1));
        end
        src_req[k] = req_en[k] && (lane_rd[k] < lane_wr[k]);
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    exp_t e;
    int   gi;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (s2p_valid) sv_cnt++;
        if (s2p_clr)   clr_cnt++;
        if (out_valid) begin
          ov_cnt++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL word_unexpected: got src=%0d data=%02h last=%0b, required none", out_src, out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            if ({out_src, out_data, out_last} !== {e.src, e.data, e.last}) begin
              n_fail++;
              $display("FAIL word: got src=%0d data=%02h last=%0b, required src=%0d data=%02h last=%0b",
                       out_src, out_data, out_last, e.src, e.data, e.last);
            end
          end
        end
        if (src_grant != '0 && prev_grant == '0) begin
          n_tests++;
          if ($countones(src_grant) != 1) begin
            n_fail++;
            $display("FAIL grant_onehot: got %b, required one-hot", src_grant);
          end
          gi = 0;
          for (int k = 0; k < N; k++) if (src_grant[k]) gi = k;
          glog = {glog[59:0], 4'(gi)}; gcnt++; grant_cyc[gi] = cyc;
        end
        if (src_done != '0) begin
          n_tests++;
          if (!(out_valid && out_last) || $countones(src_done) != 1) begin
            n_fail++;
            $display("FAIL done_with_last: got done=%b valid=%0b last=%0b, required one-hot done with last word",
                     src_done, out_valid, out_last);
          end
          gi = 0;
          for (int k = 0; k < N; k++) if (src_done[k]) gi = k;
          dlog = {dlog[59:0], 4'(gi)}; dcnt++;
        end
        if (src_err != '0) begin
          n_tests++;
          if (!s2p_clr || out_valid || out_last) begin
            n_fail++;
            $display("FAIL err_pulse: got clr=%0b valid=%0b last=%0b, required clr=1 valid=0 last=0",
                     s2p_clr, out_valid, out_last);
          end
          gi = 0;
          for (int k = 0; k < N; k++) if (src_err[k]) gi = k;
          elog = {elog[59:0], 4'(gi)}; ecnt++; err_cyc = cyc;
        end
      end
      prev_grant = src_grant;
    end
  end

  task automatic clear_bench();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      lane_wr[k] = 0; lane_rd[k] = 0; lane_cnt[k] = 0; lane_hold[k] = 1'b0; req_en[k] = 1'b0;
    end
    glog = '0; dlog = '0; elog = '0;
    gcnt = 0; dcnt = 0; ecnt = 0; sv_cnt = 0; ov_cnt = 0; clr_cnt = 0; err_cyc = 0;
    noise = 1'b0; force_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input int lane, input logic [7:0] d, input logic last, input bit expect_it);
    for (int i = 7; i >= 0; i--) begin
      lane_bits[lane][lane_wr[lane]] = d[i];
      lane_wr[lane]++;
    end
    if (expect_it) exp_q.push_back({2'(lane), d, last});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_grant != '0) && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_grant(input string name, input int lane);
    int n = 0;
    while (!src_grant[lane] && n < 50) begin @(negedge clk); n++; end
    n_tests++;
    if (!src_grant[lane]) begin
      n_fail++;
      $display("FAIL %s_grant: got grant=%b, required lane %0d", name, src_grant, lane);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({src_grant, src_done, src_err, s2p_valid, s2p_data, s2p_clr, out_valid, out_data, out_src, out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b valid=%0b out_valid=%0b data=%02h, required all zero",
               src_grant, s2p_valid, out_valid, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_src();
    do_reset();
    req_en[0] = 1'b1;
    push_word(0, 8'hA5, 1'b0, 1'b1);
    push_word(0, 8'h3C, 1'b0, 1'b1);
    push_word(0, 8'hFF, 1'b0, 1'b1);
    push_word(0, 8'h00, 1'b1, 1'b1);
    wait_drain("single", 400);
    n_tests++;
    if (ov_cnt != 4 || dcnt != 1 || dlog !== 64'h0 || ecnt != 0 || gcnt != 1) begin
      n_fail++;
      $display("FAIL single_counts: got words=%0d dones=%0d errs=%0d grants=%0d, required 4 1 0 1", ov_cnt, dcnt, ecnt, gcnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N; k++) req_en[k] = 1'b1;
    for (int k = 0; k < N; k++)
      for (int w = 0; w < 4; w++)
        push_word(k, 8'(16 * k + w + 1), (w == 3), 1'b1);
    for (int w = 0; w < 4; w++) push_word(0, 8'(8'hE0 + w), (w == 3), 1'b1);
    wait_drain("rr", 1500);
    n_tests++;
    if (gcnt != 5 || glog !== 64'h01230) begin
      n_fail++;
      $display("FAIL rr_order: got %0d grants log=%h, required 5 log=01230", gcnt, glog);
    end
    n_tests++;
    if (dcnt != 5 || dlog !== 64'h01230 || ov_cnt != 20) begin
      n_fail++;
      $display("FAIL rr_done: got %0d dones log=%h words=%0d, required 5 01230 20", dcnt, dlog, ov_cnt);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req_en[0] = 1'b1; req_en[2] = 1'b1; req_en[3] = 1'b1;
    push_word(0, 8'h11, 1'b1, 1'b1);
    push_word(2, 8'h21, 1'b0, 1'b1);
    push_word(2, 8'h22, 1'b1, 1'b1);
    push_word(3, 8'h31, 1'b1, 1'b1);
    wait_drain("drop", 600);
    n_tests++;
    if (gcnt != 3 || glog !== 64'h023 || dlog !== 64'h023) begin
      n_fail++;
      $display("FAIL drop_order: got %0d grants log=%h done=%h, required 3 023 023", gcnt, glog, dlog);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_en[0] = 1'b1; req_en[1] = 1'b1; req_en[2] = 1'b1;
    push_word(0, 8'h44, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      lane_bits[1][lane_wr[1]] = 1'(i & 1);
      lane_wr[1]++;
    end
    push_word(2, 8'h66, 1'b1, 1'b1);
    wait_drain("timeout", 600);
    n_tests++;
    if (ecnt != 1 || elog !== 64'h1 || clr_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_err: got errs=%0d lane=%h clr=%0d, required 1 1 1", ecnt, elog, clr_cnt);
    end
    n_tests++;
    if (gcnt != 3 || glog !== 64'h012 || ov_cnt != 2 || sv_cnt != 21) begin
      n_fail++;
      $display("FAIL timeout_flow: got grants=%0d log=%h words=%0d bits=%0d, required 3 012 2 21", gcnt, glog, ov_cnt, sv_cnt);
    end
    n_tests++;
    if ((err_cyc - grant_cyc[1]) < 68 || (err_cyc - grant_cyc[1]) > 72) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d cycles grant-to-err, required 68..72", err_cyc - grant_cyc[1]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_en[3] = 1'b1;
    push_word(3, 8'hC3, 1'b1, 1'b0);
    wait_grant("midrst", 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_bench();
    @(negedge clk);
    n_tests++;
    if ({src_grant, src_done, src_err, s2p_valid, s2p_data, s2p_clr, out_valid, out_data, out_src, out_last} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got grant=%b valid=%0b out_valid=%0b, required all zero", src_grant, s2p_valid, out_valid);
    end
    rst = 1'b0;
    req_en[0] = 1'b1; req_en[3] = 1'b1;
    push_word(0, 8'h5A, 1'b1, 1'b1);
    push_word(3, 8'hC3, 1'b1, 1'b1);
    wait_drain("midrst", 400);
    n_tests++;
    if (gcnt != 2 || glog !== 64'h03 || ov_cnt != 2) begin
      n_fail++;
      $display("FAIL midrst_order: got grants=%0d log=%h words=%0d, required 2 03 2", gcnt, glog, ov_cnt);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    noise = 1'b1;
    req_en[0] = 1'b1;
    push_word(0, 8'h96, 1'b1, 1'b1);
    wait_grant("spur", 0);
    repeat (3) @(negedge clk);
    force_word  = 8'hEE;
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    wait_drain("spur", 300);
    noise = 1'b0;
    n_tests++;
    if (sv_cnt != 8 || ov_cnt != 1) begin
      n_fail++;
      $display("FAIL spur_effect: got bits=%0d words=%0d, required 8 1", sv_cnt, ov_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_src();
    test_round_robin();
    test_req_drop();
    test_timeout();
    test_mid_reset();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
